// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the unified memory arbiter.
// slave = arbiter view; master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (read) and data (read/write); ARB_RR_EN selects round-robin.
// gnt one cycle after request, rvalid MEM_LAT cycles after gnt; requests hold until gnt, one access in flight.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] LAT_LD = 3'(MEM_LAT);

    state_t            state_q, state_d;
    logic              win_d_q, win_d_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_d;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;
`else
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;
`endif

    // pick_d = 1 when the data port takes the next transaction
    always_comb begin
        pick_d = bus.d_req;
        if (bus.i_req && bus.d_req) begin
`ifdef ARB_RR_EN
            pick_d = !last_d_q;
`else
            pick_d = (starve_q != STARVE_LIM);
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        win_d_d   = win_d_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_RR_EN
        last_d_d  = last_d_q;
`else
        starve_d  = starve_q;
`endif
        bus.i_gnt    = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = i_rdata_q;
        bus.d_gnt    = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = d_rdata_q;
        bus.m_en     = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_addr   = addr_q;
        bus.m_wdata  = wdata_q;
        bus.busy     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d = ISSUE;
                    win_d_d = pick_d;
                    we_d    = pick_d && bus.d_we;
                    addr_d  = pick_d ? bus.d_addr : bus.i_addr;
                    wdata_d = pick_d ? bus.d_wdata : wdata_q;
`ifdef ARB_RR_EN
                    last_d_d = pick_d;
`else
                    if (!pick_d) begin
                        starve_d = '0;
                    end else if (bus.i_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + SW'(1);
                    end
`endif
                end
            end
            ISSUE: begin
                bus.m_en  = 1'b1;
                bus.m_we  = we_q;
                bus.i_gnt = !win_d_q;
                bus.d_gnt = win_d_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_LD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // last wait cycle: memory data is on m_rdata now, forward and keep a copy
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    if (win_d_q) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.m_rdata;
                        d_rdata_d    = bus.m_rdata;
                    end else begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.m_rdata;
                        i_rdata_d    = bus.m_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_d_q  <= 1'b1;
`else
            starve_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            win_d_q   <= win_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
            last_d_q  <= last_d_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (MEM_LAT 1 and 3) with behavioural memories behind them.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct packed {
        logic          port_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic          i_gnt;
        logic          i_rvalid;
        logic [DW-1:0] i_rdata;
        logic          d_gnt;
        logic          d_rvalid;
        logic [DW-1:0] d_rdata;
        logic          m_en;
        logic          m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        logic          busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst1_n;
    logic        rst3_n;
    logic [31:0] cyc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_arb1 (
        .clk(clk), .rst_n(rst1_n), .bus(b1)
    );
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_arb3 (
        .clk(clk), .rst_n(rst3_n), .bus(b3)
    );

    // behavioural memories: read data appears exactly MEM_LAT cycles after m_en, junk otherwise
    logic [DW-1:0] mem1 [0:1023];
    logic [DW-1:0] mem3 [0:1023];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [0:2];

    always @(posedge clk) begin
        p1 <= (b1.m_en && !b1.m_we) ? mem1[b1.m_addr[9:0]] : (32'hBAD1_0000 | cyc);
        if (b1.m_en && b1.m_we) mem1[b1.m_addr[9:0]] = b1.m_wdata;
        p3[2] <= p3[1];
        p3[1] <= p3[0];
        p3[0] <= (b3.m_en && !b3.m_we) ? mem3[b3.m_addr[9:0]] : (32'hBAD3_0000 | cyc);
        if (b3.m_en && b3.m_we) mem3[b3.m_addr[9:0]] = b3.m_wdata;
    end
    assign b1.m_rdata = p1;
    assign b3.m_rdata = p3[2];

    obs_t o1, o3;
    assign o1 = {b1.i_gnt, b1.i_rvalid, b1.i_rdata, b1.d_gnt, b1.d_rvalid, b1.d_rdata,
                 b1.m_en, b1.m_we, b1.m_addr, b1.m_wdata, b1.busy};
    assign o3 = {b3.i_gnt, b3.i_rvalid, b3.i_rdata, b3.d_gnt, b3.d_rvalid, b3.d_rdata,
                 b3.m_en, b3.m_we, b3.m_addr, b3.m_wdata, b3.busy};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {~a, a} ^ 32'h5A5A_0000;
    endfunction

    function automatic gexp_t mk(input logic pd, input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd);
        gexp_t g;
        g.port_d = pd;
        g.we     = we;
        g.addr   = a;
        g.wdata  = wd;
        return g;
    endfunction

    // scoreboard queues, index 0 = MEM_LAT 1 instance, 1 = MEM_LAT 3 instance
    gexp_t         gq [2][$];
    logic [DW-1:0] iq [2][$];
    logic [DW-1:0] dq [2][$];
    int            ic [2][$];
    int            dc [2][$];
    logic          prev_men [2];
    int            lat [2] = '{1, 3};

    task automatic mon(input int k, input obs_t o, input logic rstn);
        gexp_t g;
        int    c;
        if (!rstn) begin
            ic[k].delete();
            dc[k].delete();
            prev_men[k] = 1'b0;
            return;
        end
        if (o.i_gnt || o.d_gnt) begin
            check_eq("gnt_excl", {o.i_gnt, o.d_gnt} == 2'b11, 0);
            if (gq[k].size() == 0) begin
                check_eq("gnt_unexp", {o.i_gnt, o.d_gnt}, 0);
            end else begin
                g = gq[k].pop_front();
                check_eq("gnt_port", o.d_gnt, g.port_d);
                check_eq("gnt_men", o.m_en, 1);
                check_eq("gnt_mwe", o.m_we, g.we);
                check_eq("gnt_maddr", o.m_addr, g.addr);
                if (g.we) check_eq("gnt_mwdata", o.m_wdata, g.wdata);
                if (!g.we && o.d_gnt) dc[k].push_back(int'(cyc));
                if (!g.we && o.i_gnt) ic[k].push_back(int'(cyc));
            end
        end
        if (o.m_en) check_eq("men_b2b", prev_men[k], 0);
        prev_men[k] = o.m_en;
        if (o.i_rvalid || o.d_rvalid) check_eq("rv_excl", {o.i_rvalid, o.d_rvalid} == 2'b11, 0);
        if (o.i_rvalid) begin
            if (iq[k].size() == 0 || ic[k].size() == 0) begin
                check_eq("i_rv_unexp", o.i_rvalid, 0);
            end else begin
                check_eq("i_rdata", o.i_rdata, iq[k].pop_front());
                c = ic[k].pop_front();
                check_eq("i_rv_lat", int'(cyc) - c, lat[k]);
            end
        end
        if (o.d_rvalid) begin
            if (dq[k].size() == 0 || dc[k].size() == 0) begin
                check_eq("d_rv_unexp", o.d_rvalid, 0);
            end else begin
                check_eq("d_rdata", o.d_rdata, dq[k].pop_front());
                c = dc[k].pop_front();
                check_eq("d_rv_lat", int'(cyc) - c, lat[k]);
            end
        end
    endtask

    always @(negedge clk) mon(0, o1, rst1_n);
    always @(negedge clk) mon(1, o3, rst3_n);

    // single transactions on the MEM_LAT=1 instance; called at a negedge with the arbiter idle
    task automatic fetch1(input logic [AW-1:0] a, input logic [DW-1:0] e);
        gq[0].push_back(mk(1'b0, 1'b0, a, '0));
        iq[0].push_back(e);
        b1.i_req  = 1'b1;
        b1.i_addr = a;
        @(negedge clk);
        check_eq("f_gnt_lat", b1.i_gnt, 1);
        b1.i_req = 1'b0;
        @(negedge clk);
        check_eq("f_rv_lat", b1.i_rvalid, 1);
        @(negedge clk);
        check_eq("f_idle", b1.busy, 0);
    endtask

    task automatic data1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] e);
        gq[0].push_back(mk(1'b1, we, a, wd));
        if (!we) dq[0].push_back(e);
        b1.d_req   = 1'b1;
        b1.d_we    = we;
        b1.d_addr  = a;
        b1.d_wdata = wd;
        @(negedge clk);
        check_eq("d_gnt_lat", b1.d_gnt, 1);
        b1.d_req = 1'b0;
        if (!we) begin
            @(negedge clk);
            check_eq("d_rv_lat", b1.d_rvalid, 1);
        end
        @(negedge clk);
        check_eq("d_idle", {b1.busy, b1.d_rvalid}, 0);
    endtask

    task automatic data3_read(input logic [AW-1:0] a);
        gq[1].push_back(mk(1'b1, 1'b0, a, '0));
        dq[1].push_back(pat({6'b0, a[9:0]}));
        b3.d_req  = 1'b1;
        b3.d_we   = 1'b0;
        b3.d_addr = a;
        @(negedge clk);
        check_eq("l3_gnt", b3.d_gnt, 1);
        b3.d_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("l3_early", b3.d_rvalid, 0);
        end
        @(negedge clk);
        check_eq("l3_rv", b3.d_rvalid, 1);
        @(negedge clk);
        check_eq("l3_idle", b3.busy, 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic          m_dwin [20];
        int            exp_run;
        int            run;
        int            max_run;
        int            ngnt;
        int            fi;
        int            di;
        int            starve;
        logic          last_d;
        logic [2:0]    acc;

        for (int i = 0; i < 1024; i++) begin
            mem1[i] = pat(16'(i));
            mem3[i] = pat(16'(i));
        end
        mem1[10'h040] = 32'h2402_0005;
        {b1.i_req, b1.i_addr, b1.d_req, b1.d_we, b1.d_addr, b1.d_wdata} = '0;
        {b3.i_req, b3.i_addr, b3.d_req, b3.d_we, b3.d_addr, b3.d_wdata} = '0;

        // reset held with both ports requesting
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        b1.i_req = 1'b1; b1.d_req = 1'b1;
        b3.i_req = 1'b1; b3.d_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_outs1", o1, '0);
            check_eq("rst_outs3", o3, '0);
        end
        b1.i_req = 1'b0; b1.d_req = 1'b0;
        b3.i_req = 1'b0; b3.d_req = 1'b0;
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);

        fetch1(16'h0040, 32'h2402_0005);
        check_eq("f_rdata_hold", b1.i_rdata, 32'h2402_0005);
        data1(1'b1, 16'h0010, 32'hDEAD_BEEF, '0);
        data1(1'b0, 16'h0010, '0, 32'hDEAD_BEEF);
        fetch1(16'hFFF0, pat(16'h03F0));
        for (int n = 0; n < 3; n++) begin
            a = 16'h0300 + 16'($urandom_range(0, 255));
            fetch1(a, pat(a));
            a = 16'h0300 + 16'($urandom_range(0, 255));
            data1(1'b0, a, '0, pat(a));
        end

        // both ports requesting back to back: expected grant order from a reference model
        starve = 0;
        last_d = 1'b1;
        exp_run = 0;
        run = 0;
        fi = 0;
        di = 0;
        for (int n = 0; n < 20; n++) begin
`ifdef ARB_RR_EN
            m_dwin[n] = !last_d;
            last_d    = m_dwin[n];
`else
            m_dwin[n] = (starve != 4);
            starve    = m_dwin[n] ? starve + 1 : 0;
`endif
            if (m_dwin[n]) begin
                gq[0].push_back(mk(1'b1, 1'b1, 16'h0200 + 16'(di), 32'h1000_0000 + di));
                di++;
                run++;
                if (run > exp_run) exp_run = run;
            end else begin
                gq[0].push_back(mk(1'b0, 1'b0, 16'h0100 + 16'(fi), '0));
                iq[0].push_back(pat(16'h0100 + 16'(fi)));
                fi++;
                run = 0;
            end
        end
        fi = 0;
        di = 0;
        ngnt = 0;
        run = 0;
        max_run = 0;
        b1.i_req = 1'b1; b1.i_addr = 16'h0100;
        b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 16'h0200; b1.d_wdata = 32'h1000_0000;
        for (int t = 0; t < 200 && ngnt < 20; t++) begin
            @(negedge clk);
            if (b1.i_gnt) begin
                fi++;
                b1.i_addr = 16'h0100 + 16'(fi);
                run = 0;
                ngnt++;
            end
            if (b1.d_gnt) begin
                di++;
                b1.d_addr  = 16'h0200 + 16'(di);
                b1.d_wdata = 32'h1000_0000 + di;
                run++;
                if (run > max_run) max_run = run;
                ngnt++;
            end
        end
        b1.i_req = 1'b0;
        b1.d_req = 1'b0;
        check_eq("arb_grants", ngnt, 20);
        check_eq("arb_d_run_max", max_run, exp_run);
        repeat (4) @(negedge clk);
        check_eq("arb_wr_mem", mem1[10'h200], 32'h1000_0000);
        check_eq("sb_drain1", gq[0].size() + iq[0].size() + dq[0].size(), 0);

        // MEM_LAT=3: normal read, read abandoned by reset in WAIT, then normal read again
        data3_read(16'h0033);
        check_eq("l3_hold", b3.d_rdata, pat(16'h0033));
        gq[1].push_back(mk(1'b1, 1'b0, 16'h0044, '0));
        b3.d_req  = 1'b1;
        b3.d_addr = 16'h0044;
        @(negedge clk);
        check_eq("rstw_gnt", b3.d_gnt, 1);
        b3.d_req = 1'b0;
        @(negedge clk);
        check_eq("rstw_inwait", b3.busy, 1);
        rst3_n = 1'b0;
        @(negedge clk);
        rst3_n = 1'b1;
        check_eq("rstw_busy", b3.busy, 0);
        check_eq("rstw_rdata", b3.d_rdata, 0);
        acc = '0;
        repeat (5) begin
            @(negedge clk);
            acc = acc | {b3.m_en, b3.d_rvalid, b3.busy};
        end
        check_eq("rstw_quiet", acc, 0);
        data3_read(16'h0055);
        check_eq("sb_drain3", gq[1].size() + iq[1].size() + dq[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
